fpu_dispatch: RTL
=================

// Module: fpu_dispatch
// PURPOSE
//  Initiator side of the FPU functional-unit valid/ready protocol. Accepts one FP op per
//  cycle from the core, steers it to the selected unit (fma, cast, cmp, divsqrt, ...),
//  and returns unit results to the core strictly in issue order via a unit-ID order FIFO.
//  Sits between the FPU decode stage and the per-unit datapaths.
// PARAMETERS
//  FP_FMT     fpu_pkg::FP32  operand format; FLEN = fpu_pkg::flen_bits(FP_FMT)
//  NUM_UNITS  4              number of attached functional units
//  DEPTH      4              max in-flight ops (order FIFO entries), power of 2, >=2
// PORTS
//  i_clk              in   1                     clock
//  i_rst_n            in   1                     async active-low reset
//  i_rs               in   [3:1][FLEN]           operands
//  i_op               in   FPU_OP_NUM            one-hot operation
//  i_rm               in   roundmode_e           rounding mode
//  i_unit             in   $clog2(NUM_UNITS+1)   target unit; value NUM_UNITS = illegal
//  i_in_valid         in   1                     core issue valid
//  o_in_ready         out  1                     dispatcher accepts issue
//  o_unit_rs/op/rm    out  as i_rs/i_op/i_rm     broadcast to all units
//  o_unit_in_valid    out  NUM_UNITS             per-unit issue valid
//  i_unit_in_ready    in   NUM_UNITS             per-unit issue ready
//  i_unit_result      in   [NUM_UNITS][FLEN]     per-unit result
//  i_unit_fflags      in   [NUM_UNITS] fflags_t  per-unit flags
//  i_unit_out_valid   in   NUM_UNITS             per-unit result valid
//  o_unit_out_ready   out  NUM_UNITS             per-unit result ready
//  o_result           out  FLEN                  in-order result to core
//  o_fflags           out  fflags_t              flags of o_result
//  o_out_valid        out  1                     result valid
//  i_out_ready        in   1                     core accepts result
//  i_fflags_clr       in   1                     clear accumulated flags
//  o_fflags_acc       out  fflags_t              sticky accumulated flags
// BEHAVIOUR
//  - Reset: FIFO empty (count=0, rd/wr ptr=0), o_in_ready=0 until first post-reset cycle
//    (ready is combinational on state), all valids 0, o_result=0, o_fflags=0, acc=0.
//  - Issue: fire = i_in_valid & o_in_ready. o_in_ready = (count<DEPTH) & (illegal |
//    i_unit_in_ready[i_unit]). o_unit_in_valid[k] = i_in_valid & (count<DEPTH) & i_unit==k.
//    No full-with-pop bypass: full blocks issue even if a pop occurs same cycle.
//  - On fire: push i_unit into order FIFO; wr_ptr wraps modulo DEPTH.
//  - Return: head = FIFO[rd_ptr]. Only head unit sees o_unit_out_ready = i_out_ready & !empty;
//    results from non-head units stall in their unit. o_out_valid = !empty &
//    (head illegal | i_unit_out_valid[head]); o_result/o_fflags muxed from head unit.
//  - Illegal entry (head==NUM_UNITS): o_out_valid=1 next cycle onward, o_result = canonical
//    NaN (FP32 32'h7FC0_0000), o_fflags = NV only.
//  - Pop on o_out_valid & i_out_ready; rd_ptr wraps. Push+pop same cycle: count unchanged.
//  - Min issue-to-result latency 1 cycle (FIFO is registered); empty -> o_out_valid=0.
//  - Async reset mid-operation drops all in-flight tags; units are reset by the same i_rst_n.
// CONFIGURATION
//  FPU_DISPATCH_FFLAGS_ACC_EN defined: o_fflags_acc |= o_fflags on each pop; i_fflags_clr
//   clears it (clear wins over same-cycle set, set then applies next pop).
//  Undefined: no accumulator register; o_fflags_acc tied 0, i_fflags_clr ignored.
// STRUCTURE
//  fpu_pkg additions: fpu_unit_e enum (FMA, CAST, CMP, DIVSQRT), UNIT_NUM constant,
//   canonical_nan(fmt) function, fflags_t NV field reuse.
//  Sub-module: fpu_tag_fifo (parameterised width/depth sync FIFO, count, full/empty).
// TESTING
//  1 Reset then issue FMA op, unit returns 32'h4040_0000 after 3 cycles -> o_out_valid,
//    o_result=32'h4040_0000, count back to 0.
//  2 Issue CMP (lat 1) then FMA (lat 4) -> CMP result out first, FMA second; FMA result not
//    acked while CMP head absent.
//  3 Issue CAST (lat 1) after FMA (lat 4) -> CAST held in unit (out_ready=0) until FMA popped.
//  4 Fill DEPTH=4 with i_out_ready=0 -> o_in_ready=0 on 5th; pop+issue same cycle still blocked.
//  5 i_unit=NUM_UNITS -> accepted, result 32'h7FC0_0000, fflags NV; divsqrt target with
//    in_ready=0 -> o_in_ready=0, no push.
//  6 With FPU_DISPATCH_FFLAGS_ACC_EN: pops with NX then OF -> acc=NX|OF; i_fflags_clr -> 0.

Source files
------------

// File: rtl/fpu_pkg.sv
// Shared FPU types: formats, rounding modes, exception flags, functional-unit ids
// and the canonical quiet-NaN helper used by the dispatcher for illegal ops.
package fpu_pkg;

  typedef enum logic [1:0] {
    FP32    = 2'd0,
    FP64    = 2'd1,
    FP16    = 2'd2,
    FP16ALT = 2'd3
  } fp_format_e;

  localparam int FPU_OP_NUM = 8;
  localparam int MAX_FLEN   = 64;

  typedef enum logic [2:0] {
    RNE = 3'b000,
    RTZ = 3'b001,
    RDN = 3'b010,
    RUP = 3'b011,
    RMM = 3'b100,
    DYN = 3'b111
  } roundmode_e;

  typedef struct packed {
    logic nv;
    logic dz;
    logic of;
    logic uf;
    logic nx;
  } fflags_t;

  typedef enum logic [1:0] {
    FMA     = 2'd0,
    CAST    = 2'd1,
    CMP     = 2'd2,
    DIVSQRT = 2'd3
  } fpu_unit_e;

  localparam int UNIT_NUM = 4;

  function automatic int flen_bits(fp_format_e fmt);
    case (fmt)
      FP64:    return 64;
      FP32:    return 32;
      default: return 16;
    endcase
  endfunction

  function automatic logic [MAX_FLEN-1:0] canonical_nan(fp_format_e fmt);
    case (fmt)
      FP64:    return 64'h7FF8_0000_0000_0000;
      FP32:    return 64'h0000_0000_7FC0_0000;
      FP16:    return 64'h0000_0000_0000_7E00;
      default: return 64'h0000_0000_0000_7FC0;
    endcase
  endfunction

endpackage

// File: rtl/fpu_tag_fifo.sv
// Small synchronous FIFO holding the unit id of each in-flight op in issue order.
// Head data is available combinationally; DEPTH must be a power of two.
module fpu_tag_fifo #(
  parameter int WIDTH = 3,
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic [CW-1:0]    o_count,
  output logic             o_full,
  output logic             o_empty
);

  logic [DEPTH-1:0][WIDTH-1:0] mem_q, mem_d;
  logic [PW-1:0]               wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]               rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]               count_q, count_d;
  logic                        do_push, do_pop;

  assign o_full  = (count_q == CW'(DEPTH));
  assign o_empty = (count_q == '0);
  assign o_count = count_q;
  assign o_rdata = mem_q[rd_ptr_q];

  always_comb begin
    do_push  = i_push & ~o_full;
    do_pop   = i_pop & ~o_empty;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    // Pointers are exactly PW bits wide, so the increment wraps modulo DEPTH.
    if (do_push) begin
      mem_d[wr_ptr_q] = i_wdata;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/fpu_dispatch.sv
// FPU issue dispatcher: steers ops to functional units and returns results in issue order.
// Optional sticky exception-flag accumulator enabled by FPU_DISPATCH_FFLAGS_ACC_EN.
module fpu_dispatch
  import fpu_pkg::*;
#(
  parameter fp_format_e FP_FMT    = FP32,
  parameter int         NUM_UNITS = 4,
  parameter int         DEPTH     = 4,
  localparam int FLEN = flen_bits(FP_FMT),
  localparam int UW   = $clog2(NUM_UNITS + 1)
) (
  input  logic                                i_clk,
  input  logic                                i_rst_n,
  input  logic [3:1][FLEN-1:0]                i_rs,
  input  logic [FPU_OP_NUM-1:0]               i_op,
  input  roundmode_e                          i_rm,
  input  logic [UW-1:0]                       i_unit,
  input  logic                                i_in_valid,
  output logic                                o_in_ready,
  output logic [3:1][FLEN-1:0]                o_unit_rs,
  output logic [FPU_OP_NUM-1:0]               o_unit_op,
  output roundmode_e                          o_unit_rm,
  output logic [NUM_UNITS-1:0]                o_unit_in_valid,
  input  logic [NUM_UNITS-1:0]                i_unit_in_ready,
  input  logic [NUM_UNITS-1:0][FLEN-1:0]      i_unit_result,
  input  fflags_t [NUM_UNITS-1:0]             i_unit_fflags,
  input  logic [NUM_UNITS-1:0]                i_unit_out_valid,
  output logic [NUM_UNITS-1:0]                o_unit_out_ready,
  output logic [FLEN-1:0]                     o_result,
  output fflags_t                             o_fflags,
  output logic                                o_out_valid,
  input  logic                                i_out_ready,
  input  logic                                i_fflags_clr,
  output fflags_t                             o_fflags_acc
);

  localparam logic [UW-1:0]   ILLEGAL = UW'(NUM_UNITS);
  localparam logic [FLEN-1:0] NAN_VAL = FLEN'(canonical_nan(FP_FMT));

  logic          start_q, start_d;
  logic          issue_illegal, sel_ready, can_issue, fire, pop;
  logic          full, empty, head_illegal, head_valid;
  logic [UW-1:0] head;
  logic [FLEN-1:0] head_result;
  fflags_t         head_fflags;
  logic [$clog2(DEPTH):0] unused_count;

  // Ready stays low for the first cycle after reset so the units are out of reset first.
  assign start_d = 1'b1;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) start_q <= 1'b0;
    else          start_q <= start_d;
  end

  assign o_unit_rs = i_rs;
  assign o_unit_op = i_op;
  assign o_unit_rm = i_rm;

  always_comb begin
    issue_illegal = (i_unit >= ILLEGAL);
    sel_ready     = 1'b0;
    for (int k = 0; k < NUM_UNITS; k++) begin
      if (i_unit == UW'(k)) sel_ready = i_unit_in_ready[k];
    end
    can_issue  = start_q & ~full;
    o_in_ready = can_issue & (issue_illegal | sel_ready);
    fire       = i_in_valid & o_in_ready;
  end

  for (genvar gi = 0; gi < NUM_UNITS; gi++) begin : g_unit
    assign o_unit_in_valid[gi]  = i_in_valid & can_issue & (i_unit == UW'(gi));
    assign o_unit_out_ready[gi] = i_out_ready & ~empty & (head == UW'(gi));
  end

  fpu_tag_fifo #(
    .WIDTH (UW),
    .DEPTH (DEPTH)
  ) u_tag_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (fire),
    .i_wdata (i_unit),
    .i_pop   (pop),
    .o_rdata (head),
    .o_count (unused_count),
    .o_full  (full),
    .o_empty (empty)
  );

  always_comb begin
    head_illegal = (head >= ILLEGAL);
    head_valid   = 1'b0;
    head_result  = '0;
    head_fflags  = '0;
    for (int k = 0; k < NUM_UNITS; k++) begin
      if (head == UW'(k)) begin
        head_valid  = i_unit_out_valid[k];
        head_result = i_unit_result[k];
        head_fflags = i_unit_fflags[k];
      end
    end
    if (empty) begin
      o_out_valid = 1'b0;
      o_result    = '0;
      o_fflags    = '0;
    end else if (head_illegal) begin
      // Ops sent to a non-existent unit complete as an invalid operation.
      o_out_valid = 1'b1;
      o_result    = NAN_VAL;
      o_fflags    = fflags_t'(5'b10000);
    end else begin
      o_out_valid = head_valid;
      o_result    = head_result;
      o_fflags    = head_fflags;
    end
    pop = o_out_valid & i_out_ready;
  end

`ifdef FPU_DISPATCH_FFLAGS_ACC_EN
  fflags_t acc_q, acc_d;

  always_comb begin
    acc_d = acc_q;
    if (i_fflags_clr) acc_d = '0;
    else if (pop)     acc_d = fflags_t'(acc_q | o_fflags);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) acc_q <= '0;
    else          acc_q <= acc_d;
  end

  assign o_fflags_acc = acc_q;
`else
  logic unused_fflags_clr;
  assign unused_fflags_clr = i_fflags_clr;
  assign o_fflags_acc      = '0;
`endif

endmodule
